// File: rtl/wb_timer_pkg.sv
// -----------------------------------------------------------------------------
// gr5_timer_pkg
// Shared constants for the wb_timer peripheral: register byte offsets within
// the 256-byte block, CTRL bit positions and the reset value of the compare
// register.
// -----------------------------------------------------------------------------
package gr5_timer_pkg;

  // Register byte offsets (addr_i[7:0]); bits [1:0] are ignored by the decoder
  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] MTIME_LO_OFF = 8'h04;
  localparam logic [7:0] MTIME_HI_OFF = 8'h08;
  localparam logic [7:0] CMP_LO_OFF   = 8'h0C;
  localparam logic [7:0] CMP_HI_OFF   = 8'h10;
  localparam logic [7:0] PRESCALE_OFF = 8'h14;

  // CTRL register bit indices
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_PENDING_BIT = 2;

  // Compare resets to all-ones so no interrupt fires until software programs it
  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/wb_timer_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Prescaler for the machine timer. Counts 0..DIV-1 while en is high and is
// held at 0 while en is low; tick pulses for one cycle on the wrap cycle.
//
// Ports:
//   clk    in  core clock
//   rst_n  in  asynchronous active-low reset
//   en     in  count enable (CTRL.EN)
//   tick   out one-cycle pulse every DIV enabled cycles
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  // With DIV=1 LAST is 0, so the counter never leaves 0 and tick follows en
  assign w_wrap = (r_cnt == LAST);
  assign tick   = en & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// -----------------------------------------------------------------------------
// wb_timer
// Wishbone-classic responder exposing a 64-bit machine timer (mtime) with a
// 64-bit unsigned compare and a sticky interrupt. Every accepted access is
// acknowledged with a registered single-cycle ack; read data is captured on
// the accept edge.
//
// Ports:
//   clk     in   core clock
//   rst_n   in   asynchronous active-low reset
//   cyc_i   in   bus cycle
//   stb_i   in   strobe
//   we_i    in   write enable
//   addr_i  in   byte address; block selected by addr_i[31:8]
//   data_i  in   write data
//   data_o  out  read data, valid while ack_o is high
//   ack_o   out  single-cycle acknowledge
//   irq_o   out  level interrupt = PENDING & IRQ_EN, registered
// -----------------------------------------------------------------------------
module wb_timer
  import gr5_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_FREQ = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        irq_o
);

  localparam int unsigned DIV = CLK_FREQ / TICK_FREQ;

  // Word indices (addr_i[7:2]) of the mapped registers
  localparam logic [5:0] W_CTRL     = CTRL_OFF[7:2];
  localparam logic [5:0] W_MTIME_LO = MTIME_LO_OFF[7:2];
  localparam logic [5:0] W_MTIME_HI = MTIME_HI_OFF[7:2];
  localparam logic [5:0] W_CMP_LO   = CMP_LO_OFF[7:2];
  localparam logic [5:0] W_CMP_HI   = CMP_HI_OFF[7:2];
  localparam logic [5:0] W_PRESCALE = PRESCALE_OFF[7:2];

  logic        r_ack;
  logic [31:0] r_data;
  logic        r_irq;
  logic        r_en;
  logic        r_irq_en;
  logic        r_pending;
  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic [31:0] r_shadow;

  logic        w_match;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic [5:0]  w_word;
  logic        w_tick;
  logic        w_cmp_hit;
  logic        w_clr_pending;
  logic [63:0] w_mtime_inc;
  logic [63:0] w_mtime_nxt;
  logic [31:0] w_rdata;
  logic        w_unused_ok;

  // Byte-lane bits are not decoded
  assign w_unused_ok = &{1'b0, addr_i[1:0]};

  assign w_match  = (addr_i[31:8] == BASE_ADDR[31:8]);
  // Gating on r_ack forces an idle cycle between acks when stb_i stays high
  assign w_accept = cyc_i & stb_i & w_match & ~r_ack;
  assign w_wr     = w_accept & we_i;
  assign w_rd     = w_accept & ~we_i;
  assign w_word   = addr_i[7:2];

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_en),
    .tick  (w_tick)
  );

  // A write to one half of mtime overrides that half of the tick increment;
  // the other half still takes the incremented value (including any carry)
  assign w_mtime_inc = r_mtime + 64'd1;
  always_comb begin
    w_mtime_nxt = w_tick ? w_mtime_inc : r_mtime;
    if (w_wr && (w_word == W_MTIME_LO)) w_mtime_nxt[31:0]  = data_i;
    if (w_wr && (w_word == W_MTIME_HI)) w_mtime_nxt[63:32] = data_i;
  end

  assign w_cmp_hit     = r_en & (r_mtime >= r_cmp);
  assign w_clr_pending = w_wr & (w_word == W_CTRL) & data_i[CTRL_PENDING_BIT];

  always_comb begin
    w_rdata = '0;
    case (w_word)
      W_CTRL:     w_rdata = {29'd0, r_pending, r_irq_en, r_en};
      W_MTIME_LO: w_rdata = r_mtime[31:0];
      W_MTIME_HI: w_rdata = r_shadow;
      W_CMP_LO:   w_rdata = r_cmp[31:0];
      W_CMP_HI:   w_rdata = r_cmp[63:32];
      W_PRESCALE: w_rdata = DIV;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_irq     <= 1'b0;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_pending <= 1'b0;
      r_mtime   <= '0;
      r_cmp     <= CMP_RESET;
      r_shadow  <= '0;
    end else begin
      r_ack   <= w_accept;
      r_mtime <= w_mtime_nxt;
      r_irq   <= r_pending & r_irq_en;
      // Set beats a simultaneous write-1-to-clear
      r_pending <= w_cmp_hit | (r_pending & ~w_clr_pending);

      if (w_accept) begin
        r_data <= w_rdata;
      end
      // Reading LO snapshots the upper half so a LO-then-HI pair is coherent
      if (w_rd && (w_word == W_MTIME_LO)) begin
        r_shadow <= r_mtime[63:32];
      end
      if (w_wr) begin
        case (w_word)
          W_CTRL: begin
            r_en     <= data_i[CTRL_EN_BIT];
            r_irq_en <= data_i[CTRL_IRQ_EN_BIT];
          end
          W_CMP_LO: r_cmp[31:0]  <= data_i;
          W_CMP_HI: r_cmp[63:32] <= data_i;
          default: ;
        endcase
      end
    end
  end

  assign ack_o  = r_ack;
  assign data_o = r_data;
  assign irq_o  = r_irq;

endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;
  localparam int          DIV  = 100;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc_i, stb_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o, irq_o;

  always #5 clk = ~clk;

  wb_timer #(
    .BASE_ADDR (BASE),
    .CLK_FREQ  (100_000_000),
    .TICK_FREQ (1_000_000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .ack_o  (ack_o),
    .irq_o  (irq_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: timer value as a plain 64-bit number, enabled-cycle
  // count modulo DIV, and the software-visible register contents.
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow, m_rdata;
  bit          m_en, m_ien, m_pend, m_ack, m_irq, m_last_we;
  int          m_encnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_rdata = 32'd0;
    m_en = 0; m_ien = 0; m_pend = 0; m_ack = 0; m_irq = 0; m_last_we = 0;
    m_encnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented for it
  task automatic model_step();
    bit          acc, tk, setp, clr;
    logic [63:0] nm;
    logic [5:0]  w;
    acc  = cyc_i && stb_i && (addr_i[31:8] == BASE[31:8]) && !m_ack;
    w    = addr_i[7:2];
    setp = m_en && (m_mtime >= m_cmp);
    tk   = 0;
    if (m_en) begin
      m_encnt++;
      if (m_encnt == DIV) begin tk = 1; m_encnt = 0; end
    end else begin
      m_encnt = 0;
    end
    nm    = tk ? m_mtime + 64'd1 : m_mtime;
    clr   = 0;
    m_irq = m_pend && m_ien;
    if (acc) begin
      m_last_we = we_i;
      if (!we_i) begin
        case (w)
          6'd0: m_rdata = {29'd0, m_pend, m_ien, m_en};
          6'd1: begin m_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
          6'd2: m_rdata = m_shadow;
          6'd3: m_rdata = m_cmp[31:0];
          6'd4: m_rdata = m_cmp[63:32];
          6'd5: m_rdata = DIV;
          default: m_rdata = 32'd0;
        endcase
      end else begin
        case (w)
          6'd0: begin m_en = data_i[0]; m_ien = data_i[1]; clr = data_i[2]; end
          6'd1: nm[31:0]  = data_i;
          6'd2: nm[63:32] = data_i;
          6'd3: m_cmp[31:0]  = data_i;
          6'd4: m_cmp[63:32] = data_i;
          default: ;
        endcase
      end
    end
    m_pend  = setp || (m_pend && !clr);
    m_mtime = nm;
    m_ack   = acc;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ack", ack_o, m_ack);
    chk("irq", irq_o, m_irq);
    if (m_ack && !m_last_we) chk("rdata", data_o, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input bit we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit acked);
    cyc_i = 1; stb_i = 1; we_i = we; addr_i = a; data_i = d;
    acked = 0; rd = 32'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack_o) begin acked = 1; rd = data_o; break; end
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] rd; bit ak;
    bus(1'b1, BASE | 32'(off), d, rd, ak);
    chk("wr_ack", ak, 1);
  endtask

  task automatic rdchk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd; bit ak;
    bus(1'b0, BASE | 32'(off), 32'd0, rd, ak);
    chk({name, "_ack"}, ak, 1);
    chk(name, rd, exp);
  endtask

  task automatic rdval(input logic [7:0] off, output logic [31:0] v);
    bit ak;
    bus(1'b0, BASE | 32'(off), 32'd0, v, ak);
    chk("rd_ack", ak, 1);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, v1, v2, rd, a, d;
    bit          ak, we, found;
    int          s;

    tbl[0]  = '{0, 32'h8000_0014, 32'h0,         1, 32'd100};
    tbl[1]  = '{0, 32'h8000_0000, 32'h0,         1, 32'h0};
    tbl[2]  = '{0, 32'h8000_0004, 32'h0,         1, 32'h0};
    tbl[3]  = '{0, 32'h8000_0008, 32'h0,         1, 32'h0};
    tbl[4]  = '{0, 32'h8000_000C, 32'h0,         1, 32'hFFFF_FFFF};
    tbl[5]  = '{0, 32'h8000_0010, 32'h0,         1, 32'hFFFF_FFFF};
    tbl[6]  = '{1, 32'h8000_000C, 32'h0000_1234, 1, 32'h0};
    tbl[7]  = '{0, 32'h8000_000C, 32'h0,         1, 32'h0000_1234};
    tbl[8]  = '{1, 32'h8000_0020, 32'hDEAD_BEEF, 1, 32'h0};
    tbl[9]  = '{0, 32'h8000_0020, 32'h0,         1, 32'h0};
    tbl[10] = '{0, 32'h8000_00FC, 32'h0,         1, 32'h0};
    tbl[11] = '{0, 32'h8000_000C, 32'h0,         1, 32'h0000_1234};
    tbl[12] = '{1, 32'h8000_000C, 32'hFFFF_FFFF, 1, 32'h0};
    tbl[13] = '{1, 32'h8000_0000, 32'h0000_0006, 1, 32'h0};
    tbl[14] = '{0, 32'h8000_0000, 32'h0,         1, 32'h0000_0002};
    tbl[15] = '{1, 32'h8000_0000, 32'h0000_0000, 1, 32'h0};
    tbl[16] = '{0, 32'h8000_0100, 32'h0,         0, 32'h0};

    // Reset
    cyc_i = 0; stb_i = 0; we_i = 0; addr_i = 0; data_i = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_irq", irq_o, 0);
    rst_n = 1;
    idle(2);

    // Latency and back-to-back spacing with stb held high on PRESCALE
    cyc_i = 1; stb_i = 1; we_i = 0; addr_i = 32'h8000_0014;
    step(); chk("lat_ack_n1", ack_o, 1); chk("lat_prescale", data_o, 32'd100);
    step(); chk("lat_ack_n2", ack_o, 0);
    step(); chk("b2b_ack", ack_o, 1); chk("b2b_prescale", data_o, 32'd100);
    cyc_i = 0; stb_i = 0;
    step(); chk("b2b_ack_drop", ack_o, 0);

    // Table-driven register accesses (timer disabled, so values are static)
    for (int i = 0; i < 17; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, ak);
      chk($sformatf("tbl%0d_ack", i), ak, tbl[i].exp_ack);
      if (!tbl[i].we && tbl[i].exp_ack) chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
    end

    // mtime advances once per DIV cycles, frozen with EN=0
    wr(8'h00, 32'h1);
    idle(1000);
    rdval(8'h04, v);
    chk("mtime_1000cyc_in_range", (v >= 32'd9 && v <= 32'd11), 1);
    wr(8'h00, 32'h0);
    rdval(8'h04, v1);
    idle(500);
    rdval(8'h04, v2);
    chk("mtime_frozen", v2, v1);

    // 64-bit carry through the LO/HI boundary and the HI shadow
    wr(8'h08, 32'h0);
    wr(8'h04, 32'hFFFF_FFFE);
    wr(8'h00, 32'h1);
    idle(305);
    rdchk("carry_lo", 8'h04, 32'h1);
    rdchk("carry_hi", 8'h08, 32'h1);
    wr(8'h08, 32'h7);
    rdchk("stale_shadow", 8'h08, 32'h1);
    wr(8'h00, 32'h0);

    // Compare, interrupt timing, set-beats-clear, then clear after raising cmp
    wr(8'h08, 32'h0);
    wr(8'h04, 32'h0);
    wr(8'h0C, 32'h5);
    wr(8'h10, 32'h0);
    wr(8'h00, 32'h3);
    found = 0;
    for (int i = 0; i < 700; i++) begin
      if (m_mtime == 64'd5) begin found = 1; break; end
      step();
    end
    chk("cmp_reached_in_budget", found, 1);
    chk("irq_at_match", irq_o, 0);
    step(); chk("irq_match_plus1", irq_o, 0);
    step(); chk("irq_match_plus2", irq_o, 1);
    wr(8'h00, 32'h7);
    rdchk("ctrl_pending_sticky", 8'h00, 32'h7);
    chk("irq_still_high", irq_o, 1);
    wr(8'h10, 32'hFFFF_FFFF);
    wr(8'h0C, 32'hFFFF_FFFF);
    wr(8'h00, 32'h7);
    idle(2);
    chk("irq_cleared", irq_o, 0);
    rdchk("ctrl_after_clear", 8'h00, 32'h3);
    wr(8'h00, 32'h0);

    // No-match address never acks
    cyc_i = 1; stb_i = 1; we_i = 0; addr_i = 32'h8000_0100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("nomatch_no_ack", ack_o, 0);
    end
    cyc_i = 0; stb_i = 0;
    idle(1);

    // Randomised traffic against the model
    for (int t = 0; t < 400; t++) begin
      s  = $urandom_range(0, 11);
      we = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
      case (s)
        0, 1: begin a = BASE | 32'h00; d = $urandom_range(0, 7); end
        2:    a = BASE | 32'h04;
        3:    begin a = BASE | 32'h08; d = $urandom_range(0, 1); end
        4:    a = BASE | 32'h0C;
        5:    begin a = BASE | 32'h10; d = $urandom_range(0, 1); end
        6:    a = BASE | 32'h14;
        7:    a = {24'h80_0000, 6'($urandom_range(6, 63)), 2'b00};
        8:    begin
                a = $urandom;
                if (a[31:8] == BASE[31:8]) a[31] = 1'b0;
              end
        default: begin a = BASE | 32'h04; we = 0; end
      endcase
      bus(we, a, d, rd, ak);
      chk("rnd_ack", ak, (a[31:8] == BASE[31:8]));
      if ($urandom_range(0, 19) == 0) idle(150);
      else idle($urandom_range(0, 4));
    end

    // Asynchronous reset between accept and ack
    wr(8'h0C, 32'h55);
    wr(8'h00, 32'h3);
    idle(3);
    cyc_i = 1; stb_i = 1; we_i = 1; addr_i = BASE | 32'h10; data_i = 32'hABCD;
    step();
    chk("pre_rst_ack", ack_o, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_ack", ack_o, 0);
    chk("rst_mid_irq", irq_o, 0);
    chk("rst_mid_data", data_o, 0);
    model_reset();
    cyc_i = 0; stb_i = 0; we_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rdchk("rst_ctrl", 8'h00, 32'h0);
    rdchk("rst_mtime_hi", 8'h08, 32'h0);
    rdchk("rst_mtime_lo", 8'h04, 32'h0);
    rdchk("rst_cmp_lo", 8'h0C, 32'hFFFF_FFFF);
    rdchk("rst_cmp_hi", 8'h10, 32'hFFFF_FFFF);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
